bus_transfer_sequencer: RTL and testbench

Sequences all transfers on the shared 8-bit tri-state bus between the computer's register modules. Accepts one command at a time over a valid/ready handshake: MOV, LDI, CLR or NOP. Generates per-register data_out (bus drive), data_in (latch) and clr strobes with guaranteed single-driver bus ownership. Sits beside the registers in eightbit_computer and replaces the externally driven reg*_data_in/data_out/clr pins.

---
 rtl/bus_transfer_sequencer.sv | 157 +++++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Bus transfer sequencer: owns the shared 8-bit bus, issuing drive/latch/clear strobes for MOV/LDI/CLR/NOP.
// Optional BUS_XFER_STATS_EN adds xfer_count/err_count outputs.
module bus_transfer_sequencer #(
  parameter int NUM_REGS      = 2,
  parameter int IDX_W         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_src,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic [7:0]          cmd_imm,
  output logic [NUM_REGS-1:0] reg_data_out,
  output logic [NUM_REGS-1:0] reg_data_in,
  output logic [NUM_REGS-1:0] reg_clr,
  output logic                imm_oe,
  output logic [7:0]          imm_data,
`ifdef BUS_XFER_STATS_EN
  output logic [15:0]         xfer_count,
  output logic [7:0]          err_count,
`endif
  output logic                done,
  output logic                err
);
  localparam logic [1:0] OP_NOP = 2'b00, OP_MOV = 2'b01, OP_LDI = 2'b10, OP_CLR = 2'b11;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_LATCH, S_CLEAR, S_RELEASE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [IDX_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [7:0]       imm_q, imm_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic             src_bad, dst_bad, reject;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

  always_comb begin
    src_bad = int'(cmd_src) >= NUM_REGS;
    dst_bad = int'(cmd_dst) >= NUM_REGS;
    unique case (cmd_op)
      OP_MOV:  reject = src_bad || dst_bad || (cmd_src == cmd_dst);
      OP_LDI,
      OP_CLR:  reject = dst_bad;
      default: reject = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    imm_d        = imm_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    cmd_ready    = 1'b0;
    reg_data_out = '0;
    reg_data_in  = '0;
    reg_clr      = '0;
    imm_oe       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        cnt_d     = '0;
        if (cmd_valid) begin
          op_d  = cmd_op;
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (cmd_op == OP_LDI) imm_d = cmd_imm;
          if (reject)                err_d   = 1'b1;
          else if (cmd_op == OP_NOP) done_d  = 1'b1;
          else if (cmd_op == OP_CLR) state_d = S_CLEAR;
          else                       state_d = S_DRIVE;
        end
      end
      S_DRIVE, S_LATCH: begin
        // The driver stays on through LATCH so the destination captures a settled bus.
        if (op_q == OP_LDI) imm_oe = 1'b1;
        else                reg_data_out = onehot(src_q);
        if (state_q == S_LATCH) begin
          reg_data_in = onehot(dst_q);
          state_d     = S_RELEASE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CLEAR: begin
        reg_clr = onehot(dst_q);
        state_d = S_RELEASE;
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      src_q   <= '0;
      dst_q   <= '0;
      imm_q   <= 8'h00;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imm_data = imm_q;
  assign done     = done_q | (state_q == S_RELEASE);
  assign err      = err_q;

`ifdef BUS_XFER_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;
  logic [7:0]  err_count_q, err_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q + ((state_q == S_RELEASE) ? 16'd1 : 16'd0);
    err_count_d  = err_count_q;
    if (err_q && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
      err_count_q  <= err_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
  assign err_count  = err_count_q;
`endif
endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Randomized bench for bus_transfer_sequencer: command-level schedule model plus a bus/register-file model.
module tb_bus_transfer_sequencer;
  localparam int NR = 2;
  localparam int IW = 3;
  localparam int ST = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [IW-1:0] cmd_src = '0, cmd_dst = '0;
  logic [7:0] cmd_imm = '0, imm_data;
  logic [NR-1:0] reg_data_out, reg_data_in, reg_clr;
  logic imm_oe, done, err;
`ifdef BUS_XFER_STATS_EN
  logic [15:0] xfer_count;
  logic [7:0] err_count;
`endif

  bus_transfer_sequencer #(.NUM_REGS(NR), .IDX_W(IW), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_data_out(reg_data_out), .reg_data_in(reg_data_in), .reg_clr(reg_clr),
    .imm_oe(imm_oe), .imm_data(imm_data),
`ifdef BUS_XFER_STATS_EN
    .xfer_count(xfer_count), .err_count(err_count),
`endif
    .done(done), .err(err));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NR-1:0] out, in, clr;
    logic oe, dn, er, busy;
  } slot_t;

  slot_t sched[$];
  logic [7:0] m[NR];   // command-level register contents
  logic [7:0] br[NR];  // contents observed by snooping the bus strobes
  logic [7:0] exp_imm = 8'h00;
  int total = 0, bad = 0;
`ifdef BUS_XFER_STATS_EN
  logic [15:0] exp_xfer = '0;
  logic [7:0] exp_errc = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each accepted command expands into its list of per-cycle output slots.
  always @(posedge clk) begin
    if (!rst_n) begin
      sched.delete();
      exp_imm = 8'h00;
`ifdef BUS_XFER_STATS_EN
      exp_xfer = '0; exp_errc = '0;
`endif
    end else begin
      bit rdy, ok;
      slot_t s;
      rdy = (sched.size() == 0) || !sched[0].busy;
`ifdef BUS_XFER_STATS_EN
      if (sched.size() != 0 && sched[0].dn && sched[0].busy) exp_xfer++;
      if (sched.size() != 0 && sched[0].er && exp_errc != 8'hFF) exp_errc++;
`endif
      if (sched.size() != 0) void'(sched.pop_front());
      if (cmd_valid && rdy) begin
        case (cmd_op)
          2'b01:   ok = cmd_src < NR && cmd_dst < NR && cmd_src != cmd_dst;
          2'b10,
          2'b11:   ok = cmd_dst < NR;
          default: ok = 1'b1;
        endcase
        if (cmd_op == 2'b10) exp_imm = cmd_imm;
        s = '0;
        if (!ok) begin
          s.er = 1'b1; sched.push_back(s);
        end else if (cmd_op == 2'b00) begin
          s.dn = 1'b1; sched.push_back(s);
        end else if (cmd_op == 2'b11) begin
          s.busy = 1'b1; s.clr = NR'(1) << cmd_dst; sched.push_back(s);
          s = '0; s.busy = 1'b1; s.dn = 1'b1; sched.push_back(s);
          m[cmd_dst] = 8'h00;
        end else begin
          s.busy = 1'b1;
          if (cmd_op == 2'b10) s.oe = 1'b1; else s.out = NR'(1) << cmd_src;
          for (int k = 0; k < ST; k++) sched.push_back(s);
          s.in = NR'(1) << cmd_dst; sched.push_back(s);
          s = '0; s.busy = 1'b1; s.dn = 1'b1; sched.push_back(s);
          m[cmd_dst] = (cmd_op == 2'b10) ? cmd_imm : m[cmd_src];
        end
      end
    end
  end

  // Compare process: outputs against the model, bus invariants, snooped register file.
  always @(negedge clk) begin
    if (rst_n) begin
      slot_t e;
      logic [7:0] bus;
      e = (sched.size() != 0) ? sched[0] : '0;
      chk("cmd_ready", cmd_ready, (sched.size() == 0) || !e.busy);
      chk("reg_data_out", reg_data_out, e.out);
      chk("reg_data_in", reg_data_in, e.in);
      chk("reg_clr", reg_clr, e.clr);
      chk("imm_oe", imm_oe, e.oe);
      chk("done", done, e.dn);
      chk("err", err, e.er);
      chk("imm_data", imm_data, exp_imm);
      chk("single_driver", ($countones(reg_data_out) + imm_oe) <= 1, 1);
      chk("onehot_in_clr", ($countones(reg_data_in) <= 1) && ($countones(reg_clr) <= 1), 1);
      chk("done_err_excl", done & err, 0);
`ifdef BUS_XFER_STATS_EN
      chk("xfer_count", xfer_count, exp_xfer);
      chk("err_count", err_count, exp_errc);
`endif
      bus = imm_oe ? imm_data : 8'h00;
      for (int i = 0; i < NR; i++) if (reg_data_out[i]) bus = br[i];
      for (int i = 0; i < NR; i++) begin
        if (reg_data_in[i]) br[i] = bus;
        if (reg_clr[i]) br[i] = 8'h00;
      end
      if (sched.size() == 0)
        for (int i = 0; i < NR; i++) chk($sformatf("reg%0d", i), br[i], m[i]);
    end
  end

  task automatic send(input logic [1:0] op, input int src, input int dst, input logic [7:0] imm);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = IW'(src); cmd_dst = IW'(dst); cmd_imm = imm;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!(cmd_ready && !done && !err) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m[i] = 8'h00; br[i] = 8'h00; end
    repeat (2) @(negedge clk);
    chk("rst_out", {reg_data_out, reg_data_in, reg_clr, imm_oe, done, err}, 0);
    chk("rst_imm", imm_data, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // LDI reg0=A5, then MOV 0->1 with literal timeline.
    send(2'b10, 0, 0, 8'hA5); wait_idle();
    send(2'b01, 0, 1, 8'h00);
    @(negedge clk); chk("mov_c1_out", reg_data_out, 2'b01); chk("mov_c1_in", reg_data_in, 2'b00);
    @(negedge clk); chk("mov_c2_out", reg_data_out, 2'b01); chk("mov_c2_in", reg_data_in, 2'b10);
    @(negedge clk); chk("mov_c3_done", done, 1); chk("mov_c3_out", reg_data_out, 2'b00);
    chk("mov_reg1", br[1], 8'hA5);

    send(2'b10, 0, 0, 8'h3C);
    @(negedge clk); chk("ldi_c1_oe", imm_oe, 1); chk("ldi_c1_in", reg_data_in, 2'b00);
    @(negedge clk); chk("ldi_c2_oe", imm_oe, 1); chk("ldi_c2_in", reg_data_in, 2'b01);
    @(negedge clk); chk("ldi_c3_done", done, 1); chk("ldi_c3_oe", imm_oe, 0);
    chk("ldi_reg0", br[0], 8'h3C); chk("ldi_imm", imm_data, 8'h3C);

    send(2'b11, 0, 1, 8'h00);
    @(negedge clk); chk("clr_c1", reg_clr, 2'b10); chk("clr_c1_done", done, 0);
    @(negedge clk); chk("clr_c2_done", done, 1); chk("clr_c2", reg_clr, 2'b00);
    @(negedge clk); chk("clr_reg1", br[1], 8'h00);

    send(2'b01, 1, 1, 8'h00);
    @(negedge clk); chk("err_same", err, 1); chk("err_same_rdy", cmd_ready, 1);
    chk("err_same_out", reg_data_out, 2'b00);
    send(2'b01, 2, 0, 8'h00);
    @(negedge clk); chk("err_range", err, 1); chk("err_range_done", done, 0);
    send(2'b00, 0, 0, 8'h00);
    @(negedge clk); chk("nop_done", done, 1); chk("nop_rdy", cmd_ready, 1);

    // Random traffic, mostly valid indices, with back-to-back and idle gaps.
    for (int t = 0; t < 400; t++) begin
      int g;
      send(2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? $urandom_range(2, 7) : $urandom_range(0, NR - 1),
           ($urandom_range(0, 7) == 0) ? $urandom_range(2, 7) : $urandom_range(0, NR - 1), 8'($urandom));
      g = $urandom_range(0, 3);
      if (g == 3) wait_idle();
      else repeat (g) @(posedge clk);
      #1;
    end
    wait_idle();

    // Reset during DRIVE of a MOV: enables must drop before the next edge.
    send(2'b01, 0, 1, 8'h00);
    @(negedge clk); chk("abort_drive", reg_data_out, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out", {reg_data_out, reg_data_in, reg_clr, imm_oe}, 0);
    chk("abort_flags", {done, err}, 0);
    chk("abort_imm", imm_data, 8'h00);
    @(negedge clk);
    m[1] = br[1];
    rst_n = 1'b1;
    chk("abort_rdy", cmd_ready, 1);
    @(negedge clk); chk("abort_no_done", done, 0);

    send(2'b10, 1, 1, 8'h5A); wait_idle();
    send(2'b01, 1, 0, 8'h00); wait_idle();
    @(negedge clk); chk("post_reg0", br[0], 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
